// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential binary32 divider, out_fp = a_fp / b_fp.
// Restoring mantissa division producing BITS_PER_CYC quotient bits per
// clock, then one normalise/pack cycle. One operation in flight, with a
// valid/ready handshake on both sides.
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise
// the quotient is truncated, matching the FMA datapath.
module fp_div_seq #(
  parameter int BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_fp,
  input  logic [31:0] b_fp,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_fp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int         N        = 26 / BITS_PER_CYC;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t state_q, state_d;

  // Control registers
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;

  // Datapath registers (no reset needed, always loaded on accept)
  logic [24:0] r_q, r_d;
  logic [25:0] q_q, q_d;
  logic [23:0] mb_q, mb_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic        sgn_q, sgn_d;

  logic        accept;
  logic        sp_hit;
  logic [31:0] sp_res;

  logic [24:0] r_step;
  logic [25:0] q_step;

  logic signed [9:0] norm_e;
  logic [22:0]       norm_frac;
  logic              norm_g;
  logic              norm_s;
  logic signed [9:0] fin_e;
  logic [22:0]       fin_frac;
  logic [31:0]       norm_res;

  // Saturating pack: overflow to signed infinity, underflow flushes to zero
  function automatic logic [31:0] pack_result(input logic sgn,
                                              input logic signed [9:0] e,
                                              input logic [22:0] frac);
    if (e >= 10'sd255)
      return {sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return {sgn, 31'd0};
    else
      return {sgn, e[7:0], frac};
  endfunction

`ifdef FP_DIV_RNE_EN
  // Round-to-nearest-even on the 23-bit fraction; a carry out of the
  // fraction means the mantissa rolled over to 2.0, so bump the exponent
  function automatic logic [32:0] round_rne(input logic signed [9:0] e,
                                            input logic [22:0] frac,
                                            input logic g,
                                            input logic s);
    logic [23:0]       f_r;
    logic signed [9:0] e_r;
    f_r = {1'b0, frac};
    if (g & (s | frac[0]))
      f_r = f_r + 24'd1;
    e_r = e + (f_r[23] ? 10'sd1 : 10'sd0);
    return {e_r, f_r[22:0]};
  endfunction
`endif

  assign accept = in_valid & in_ready;

  // Special-operand classification, evaluated on the live inputs at accept
  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    a_zero = (a_fp[30:23] == 8'd0);
    b_zero = (b_fp[30:23] == 8'd0);
    a_inf  = (a_fp[30:23] == 8'hFF) & (a_fp[22:0] == 23'd0);
    b_inf  = (b_fp[30:23] == 8'hFF) & (b_fp[22:0] == 23'd0);
    a_nan  = (a_fp[30:23] == 8'hFF) & (a_fp[22:0] != 23'd0);
    b_nan  = (b_fp[30:23] == 8'hFF) & (b_fp[22:0] != 23'd0);
    sgn    = a_fp[31] ^ b_fp[31];
    sp_hit = 1'b1;
    sp_res = 32'h7FC00000;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
      sp_res = 32'h7FC00000;
    else if (b_zero | a_inf)
      sp_res = {sgn, 8'hFF, 23'd0};
    else if (a_zero | b_inf)
      sp_res = {sgn, 31'd0};
    else
      sp_hit = 1'b0;
  end

  // BITS_PER_CYC restoring steps, MSB of the quotient first
  always_comb begin
    r_step = r_q;
    q_step = q_q;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (r_step >= {1'b0, mb_q}) begin
        q_step = {q_step[24:0], 1'b1};
        r_step = r_step - {1'b0, mb_q};
      end else begin
        q_step = {q_step[24:0], 1'b0};
      end
      r_step = r_step << 1;
    end
  end

  // Normalise: quotient lies in (0.5, 2), so at most one position of shift
  always_comb begin
    norm_e = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
             + (q_q[25] ? 10'sd127 : 10'sd126);
    if (q_q[25]) begin
      norm_frac = q_q[24:2];
      norm_g    = q_q[1];
      norm_s    = q_q[0] | (r_q != 25'd0);
    end else begin
      norm_frac = q_q[23:1];
      norm_g    = q_q[0];
      norm_s    = (r_q != 25'd0);
    end
  end

`ifdef FP_DIV_RNE_EN
  assign {fin_e, fin_frac} = round_rne(norm_e, norm_frac, norm_g, norm_s);
`else
  logic unused_round;
  assign unused_round = norm_g ^ norm_s;
  assign fin_e        = norm_e;
  assign fin_frac     = norm_frac;
`endif

  assign norm_res = pack_result(sgn_q, fin_e, fin_frac);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = sp_hit ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt_q == CNT_LAST) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Control next-state: step counter and held result
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (accept) begin
      cnt_d = 5'd0;
      if (sp_hit)
        out_d = sp_res;
    end else if (state_q == S_DIVIDE) begin
      cnt_d = cnt_q + 5'd1;
    end else if (state_q == S_NORM) begin
      out_d = norm_res;
    end
  end

  // Control registers, cleared by reset so an aborted op leaves nothing behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 5'd0;
      out_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // Datapath next-state: capture operands on accept, iterate while dividing
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    mb_d  = mb_q;
    ea_d  = ea_q;
    eb_d  = eb_q;
    sgn_d = sgn_q;
    if (accept) begin
      r_d   = {2'b01, a_fp[22:0]};
      q_d   = 26'd0;
      mb_d  = {1'b1, b_fp[22:0]};
      ea_d  = a_fp[30:23];
      eb_d  = b_fp[30:23];
      sgn_d = a_fp[31] ^ b_fp[31];
    end else if (state_q == S_DIVIDE) begin
      r_d = r_step;
      q_d = q_step;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    r_q   <= r_d;
    q_q   <= q_d;
    mb_q  <= mb_d;
    ea_q  <= ea_d;
    eb_q  <= eb_d;
    sgn_q <= sgn_d;
  end

  assign out_fp = out_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Testbench for fp_div_seq: directed vector table, hand-written handshake
// and reset sequences, and randomized operands checked against an
// arithmetic reference model. A second instance uses BITS_PER_CYC=2.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_fp = 32'd0, b_fp = 32'd0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_fp;

  logic [31:0] a2_fp = 32'd0, b2_fp = 32'd0;
  logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_fp2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.BITS_PER_CYC(1)) dut (
    .clk(clk), .rst(rst), .a_fp(a_fp), .b_fp(b_fp),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_fp(out_fp), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  fp_div_seq #(.BITS_PER_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .a_fp(a2_fp), .b_fp(b2_fp),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .out_fp(out_fp2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference model: exact integer quotient of the mantissas, then the
  // normalisation, rounding and range rules applied arithmetically.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    int ea, eb, e;
    logic sg, za, zb, ia, ib, na, nb;
    longint unsigned num, den, q, frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sg = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    lat = 1;
    if (na || nb || (za && zb) || (ia && ib)) r = 32'h7FC00000;
    else if (zb || ia) r = {sg, 8'hFF, 23'd0};
    else if (za || ib) r = {sg, 31'd0};
    else begin
      lat = 28;
      num = {40'd0, 1'b1, a[22:0]} << 25;
      den = {40'd0, 1'b1, b[22:0]};
      q = num / den;
      if (q >= 64'd33554432) begin
        frac = (q >> 2) & 64'h7FFFFF;
        e = ea - eb + 127;
      end else begin
        frac = (q >> 1) & 64'h7FFFFF;
        e = ea - eb + 126;
      end
`ifdef FP_DIV_RNE_EN
      begin : rne
        logic g, s;
        longint unsigned rem;
        rem = num % den;
        if (q >= 64'd33554432) begin
          g = q[1];
          s = q[0] | (rem != 0);
        end else begin
          g = q[0];
          s = (rem != 0);
        end
        if (g && (s || frac[0])) frac = frac + 1;
        if (frac == 64'h800000) begin
          frac = 0;
          e = e + 1;
        end
      end
`endif
      if (e >= 255) r = {sg, 8'hFF, 23'd0};
      else if (e <= 0) r = {sg, 31'd0};
      else r = {sg, 8'(e), 23'(frac)};
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = int'($urandom_range(0, 15));
    f = 23'($urandom);
    if (k == 0) e = 8'd0;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end
    else if (k == 2) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(100, 154));
    return {1'($urandom), e, f};
  endfunction

  // One operation on the BITS_PER_CYC=1 instance. lat counts clock edges
  // from the accept edge (inclusive) to the first edge after which
  // out_valid is seen high; -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rdy,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    a_fp = a;
    b_fp = b;
    in_valid = 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_fp = $urandom;
    b_fp = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = out_fp;
    if (!out_valid) lat = -1;
  endtask

  initial begin
    logic [31:0] res, want;
    int lat, wlat;

    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 28};
`ifdef FP_DIV_RNE_EN
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28};
`else
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28};
`endif
    tbl[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1};
    tbl[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1};
    tbl[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 28};
    tbl[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 28};
    tbl[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1};
    tbl[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1};
    tbl[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    tbl[9]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1};
    tbl[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1};
    tbl[11] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1};
    tbl[12] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 1};
    tbl[13] = '{32'hC0400000, 32'h3F800000, 32'hC0400000, 28};
    tbl[14] = '{32'h40400000, 32'h40400000, 32'h3F800000, 28};
    tbl[15] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 28};
    tbl[16] = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 1};
    tbl[17] = '{32'h00000000, 32'h7F800000, 32'h00000000, 1};

    // Reset state, observed while rst is still asserted
    #12;
    chk("reset_state", {31'd0, in_ready, out_valid, busy, out_fp},
        {31'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b1, res, lat);
      chk($sformatf("vec%0d_result", i), 64'(res), 64'(tbl[i].want));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Held result in DONE while the consumer stalls
    run_op(32'h40C00000, 32'h40000000, 1'b0, res, lat);
    chk("hold_first", {30'd0, out_valid, in_ready, res}, {30'd0, 1'b1, 1'b0, 32'h40400000});
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold_cyc%0d", c), {29'd0, out_valid, in_ready, busy, out_fp},
          {29'd0, 1'b1, 1'b0, 1'b1, 32'h40400000});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    // Reset in the middle of DIVIDE aborts the operation
    @(negedge clk);
    a_fp = 32'h40C00000;
    b_fp = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_reset", {28'd0, in_ready, out_valid, busy, out_fp},
        {28'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h40800000, 32'h40000000, 1'b1, res, lat);
    chk("after_abort_result", 64'(res), 64'h40000000);
    chk("after_abort_latency", 64'(lat), 64'd28);

    // Two quotient bits per cycle instance: N=13, latency 15
    @(negedge clk);
    a2_fp = 32'h40C00000;
    b2_fp = 32'h40000000;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    a2_fp = 32'h3F800000;
    lat = 1;
    @(negedge clk);
    while (!out_valid2 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid2) lat = -1;
    chk("bpc2_result", 64'(out_fp2), 64'h40400000);
    chk("bpc2_latency", 64'(lat), 64'd15);

    // Randomized operands against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      ref_div(ra, rb, want, wlat);
      run_op(ra, rb, 1'b1, res, lat);
      chk($sformatf("rand%0d_%h_%h", i, ra, rb), 64'(res), 64'(want));
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(wlat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
